// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM arbiter slice: address/data widths of the
// sdram_controller user port and the arbiter state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    // One access walks IDLE -> BUSY -> DONE -> IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage : sdram_pkg

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
// Bundles the requester-side and controller-side signals of sdram_arbiter.
//   req_Valid/Lock/WE  per-port request, lock request and direction
//   req_Addr/Din       packed per-port address and write data
//   req_Grant/Ack      one-hot owner and one-cycle completion pulse
//   req_Dout           read data returned to the owner
//   sdram_*            access towards sdram_controller (Req/Addr/Din/WE/Focus)
//                      and its completion (R) plus read data (Dout)
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system (requesters + controller)
// -----------------------------------------------------------------------------
interface sdram_arbiter_if
    import sdram_pkg::*;
#(
    parameter int N_PORTS = 3
);

    logic [N_PORTS-1:0]        req_Valid;
    logic [N_PORTS-1:0]        req_Lock;
    logic [N_PORTS-1:0]        req_WE;
    logic [N_PORTS*ADDR_W-1:0] req_Addr;
    logic [N_PORTS*DATA_W-1:0] req_Din;
    logic [N_PORTS-1:0]        req_Grant;
    logic [N_PORTS-1:0]        req_Ack;
    logic [DATA_W-1:0]         req_Dout;

    logic                      sdram_Req;
    logic [ADDR_W-1:0]         sdram_Addr;
    logic [DATA_W-1:0]         sdram_Din;
    logic                      sdram_WE;
    logic                      sdram_Focus;
    logic                      sdram_R;
    logic [DATA_W-1:0]         sdram_Dout;

    modport slave (
        input  req_Valid, req_Lock, req_WE, req_Addr, req_Din,
        output req_Grant, req_Ack, req_Dout,
        output sdram_Req, sdram_Addr, sdram_Din, sdram_WE, sdram_Focus,
        input  sdram_R, sdram_Dout
    );

    modport master (
        output req_Valid, req_Lock, req_WE, req_Addr, req_Din,
        input  req_Grant, req_Ack, req_Dout,
        input  sdram_Req, sdram_Addr, sdram_Din, sdram_WE, sdram_Focus,
        output sdram_R, sdram_Dout
    );

endinterface : sdram_arbiter_if

// File: rtl/sdram_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Returns the first set bit of req at or
// above index start, wrapping to the lowest set bit when none is found above.
//   req        in  N      request vector
//   start      in  PTR_W  index where the search begins
//   grant      out N      one-hot selection (zero when req is zero)
//   any_valid  out 1      at least one request is set
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic             any_valid
);

    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;

    // Requests at index >= start take priority over the wrapped-around ones.
    assign upper_mask = {N{1'b1}} << start;
    assign upper_req  = req & upper_mask;

    // x & -x isolates the lowest set bit.
    assign grant     = (|upper_req) ? (upper_req & (-upper_req)) : (req & (-req));
    assign any_valid = |req;

endmodule : rr_picker

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares one sdram_controller between N_PORTS requesters. Round-robin
// arbitration with an optional per-owner lock that keeps ownership for
// back-to-back accesses and raises sdram_Focus to hold off refresh. A lock is
// forcibly dropped after MAX_LOCK consecutive accesses.
//   Clk    in  system clock, rising edge
//   Reset  in  synchronous, active-high
//   bus    sdram_arbiter_if.slave: requester ports (req_*) and controller
//          port (sdram_*)
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int N_PORTS  = 3,
    parameter int MAX_LOCK = 64
) (
    input  logic           Clk,
    input  logic           Reset,
    sdram_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Registered state
    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               lock_active_q, lock_active_d;
    logic [N_PORTS-1:0] lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [N_PORTS-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               we_q, we_d;

    // Arbitration helpers
    logic [N_PORTS-1:0] pick;
    logic               pick_any;
    logic               owner_valid;
    logic               owner_lock;
    logic               lock_hold;
    logic               force_rel;
    logic               release_now;
    logic               take_lock;
    logic [N_PORTS-1:0] grant_sel;
    logic               grant_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_din;
    logic               sel_we;
    logic [PTR_W-1:0]   rr_next;
    logic               focus;

    rr_picker #(
        .N     (N_PORTS),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req       (bus.req_Valid),
        .start     (rr_ptr_q),
        .grant     (pick),
        .any_valid (pick_any)
    );

    assign owner_valid = |(bus.req_Valid & lock_owner_q);
    assign owner_lock  = |(bus.req_Lock & lock_owner_q);

    // The owner keeps the port only while it still asks for it and has not
    // used up its quota of consecutive accesses.
    assign lock_hold   = lock_active_q && owner_valid && owner_lock && (lock_cnt_q != CNT_MAX);
    assign force_rel   = lock_active_q && (lock_cnt_q == CNT_MAX);
    assign release_now = (state_q == IDLE) && lock_active_q && !lock_hold;

    assign grant_sel = lock_hold ? lock_owner_q : pick;
    assign grant_any = lock_hold | pick_any;

    // After a forced release the old owner may still win round-robin, but it
    // must not re-lock on that grant.
    assign take_lock = (|(bus.req_Lock & grant_sel))
                       && !(force_rel && (grant_sel == lock_owner_q));

    // Focus drops combinationally in the IDLE cycle that lets the lock go.
    assign focus = lock_active_q && !release_now;

    // Field mux for the selected port.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_sel[i]) begin
                sel_addr = bus.req_Addr[i*ADDR_W +: ADDR_W];
                sel_din  = bus.req_Din[i*DATA_W +: DATA_W];
                sel_we   = bus.req_WE[i];
            end
        end
    end

    // Pointer to the port after the current owner; the last port wraps to 0.
    always_comb begin
        rr_next = '0;
        for (int i = 0; i < N_PORTS - 1; i++) begin
            if (grant_q[i]) begin
                rr_next = PTR_W'(i + 1);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        lock_cnt_d    = lock_cnt_q;
        grant_d       = grant_q;
        ack_d         = '0;
        dout_d        = dout_q;
        req_d         = req_q;
        addr_d        = addr_q;
        din_d         = din_q;
        we_d          = we_q;

        unique case (state_q)
            IDLE: begin
                if (lock_hold) begin
                    lock_cnt_d = lock_cnt_q + CNT_ONE;
                end else if (take_lock) begin
                    lock_active_d = 1'b1;
                    lock_owner_d  = grant_sel;
                    lock_cnt_d    = CNT_ONE;
                end else begin
                    lock_active_d = 1'b0;
                    lock_owner_d  = '0;
                    lock_cnt_d    = '0;
                end

                if (grant_any) begin
                    grant_d = grant_sel;
                    addr_d  = sel_addr;
                    din_d   = sel_din;
                    we_d    = sel_we;
                    req_d   = 1'b1;
                    state_d = BUSY;
                end else begin
                    grant_d = '0;
                end
            end

            BUSY: begin
                if (bus.sdram_R) begin
                    req_d = 1'b0;
                    ack_d = grant_q;
                    // Writes leave the last read value in place.
                    if (!we_q) begin
                        dout_d = bus.sdram_Dout;
                    end
                    state_d = DONE;
                end
            end

            DONE: begin
                rr_ptr_d = rr_next;
                if (!lock_active_q) begin
                    grant_d = '0;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (Reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
            lock_cnt_q    <= '0;
            grant_q       <= '0;
            ack_q         <= '0;
            dout_q        <= '0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            lock_cnt_q    <= lock_cnt_d;
            grant_q       <= grant_d;
            ack_q         <= ack_d;
            dout_q        <= dout_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            we_q          <= we_d;
        end
    end

    assign bus.req_Grant   = grant_q;
    assign bus.req_Ack     = ack_q;
    assign bus.req_Dout    = dout_q;
    assign bus.sdram_Req   = req_q;
    assign bus.sdram_Addr  = addr_q;
    assign bus.sdram_Din   = din_q;
    assign bus.sdram_WE    = we_q;
    assign bus.sdram_Focus = focus;

endmodule : sdram_arbiter

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Self-checking bench for sdram_arbiter (3 ports, MAX_LOCK = 4). A small
// controller model answers each access after a programmable latency with
// read data derived from the address.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int N    = 3;
    localparam int MAXL = 4;
    localparam int NV   = 25;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] lock;
        logic [N-1:0] we;
        int           lat;
        logic [N-1:0] exp_grant;
        logic         exp_focus;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.N_PORTS(N)) bus ();

    sdram_arbiter #(
        .N_PORTS  (N),
        .MAX_LOCK (MAXL)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] port_addr [N];
    logic [DATA_W-1:0] port_din  [N];
    vec_t              vecs      [NV];
    logic [DATA_W-1:0] last_rd;
    int                cyc;
    int                acks_seen;

    // Controller model
    int                lat_cfg    = 1;
    int                ctl_cnt    = 0;
    logic              r_model    = 1'b0;
    logic              r_force    = 1'b0;
    logic [DATA_W-1:0] dout_model = '0;

    assign bus.sdram_R    = r_model | r_force;
    assign bus.sdram_Dout = dout_model;

    function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hBFCC;
    endfunction

    function automatic int oh2i(input logic [N-1:0] g);
        int r = 0;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        r_model = 1'b0;
        if (rst || !bus.sdram_Req) begin
            ctl_cnt = 0;
        end else begin
            ctl_cnt++;
            if (ctl_cnt >= lat_cfg) begin
                r_model    = 1'b1;
                dout_model = rd_data(bus.sdram_Addr);
                ctl_cnt    = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int c = 0;
        @(negedge clk);
        while (!bus.sdram_Req && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, " req"}, 32'(bus.sdram_Req), 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        int c = 0;
        while (bus.req_Ack == '0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, " ack_seen"}, 32'(|bus.req_Ack), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " grant"}, 32'(bus.req_Grant),   32'd0);
        check({tag, " ack"},   32'(bus.req_Ack),     32'd0);
        check({tag, " dout"},  32'(bus.req_Dout),    32'd0);
        check({tag, " req"},   32'(bus.sdram_Req),   32'd0);
        check({tag, " addr"},  32'(bus.sdram_Addr),  32'd0);
        check({tag, " din"},   32'(bus.sdram_Din),   32'd0);
        check({tag, " we"},    32'(bus.sdram_WE),    32'd0);
        check({tag, " focus"}, 32'(bus.sdram_Focus), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        port_addr[0] = 25'h1000040;
        port_addr[1] = 25'h0000123;
        port_addr[2] = 25'h0ABCDEF;
        port_din[0]  = 16'h1111;
        port_din[1]  = 16'h2222;
        port_din[2]  = 16'h3333;

        //            valid   lock    we      lat grant   focus
        vecs[0]  = '{3'b111, 3'b000, 3'b010, 1, 3'b001, 1'b0};
        vecs[1]  = '{3'b111, 3'b000, 3'b010, 2, 3'b010, 1'b0};
        vecs[2]  = '{3'b111, 3'b000, 3'b010, 3, 3'b100, 1'b0};
        vecs[3]  = '{3'b111, 3'b000, 3'b101, 1, 3'b001, 1'b0};
        vecs[4]  = '{3'b111, 3'b000, 3'b101, 2, 3'b010, 1'b0};
        vecs[5]  = '{3'b111, 3'b000, 3'b101, 1, 3'b100, 1'b0};
        vecs[6]  = '{3'b100, 3'b100, 3'b100, 2, 3'b100, 1'b1};
        vecs[7]  = '{3'b111, 3'b100, 3'b100, 1, 3'b100, 1'b1};
        vecs[8]  = '{3'b111, 3'b100, 3'b100, 3, 3'b100, 1'b1};
        vecs[9]  = '{3'b111, 3'b100, 3'b100, 1, 3'b100, 1'b1};
        vecs[10] = '{3'b011, 3'b000, 3'b000, 2, 3'b001, 1'b0};
        vecs[11] = '{3'b001, 3'b001, 3'b001, 1, 3'b001, 1'b1};
        vecs[12] = '{3'b111, 3'b001, 3'b001, 2, 3'b001, 1'b1};
        vecs[13] = '{3'b111, 3'b001, 3'b001, 1, 3'b001, 1'b1};
        vecs[14] = '{3'b111, 3'b001, 3'b001, 1, 3'b001, 1'b1};
        vecs[15] = '{3'b111, 3'b001, 3'b000, 2, 3'b010, 1'b0};
        vecs[16] = '{3'b111, 3'b001, 3'b000, 1, 3'b100, 1'b0};
        vecs[17] = '{3'b111, 3'b001, 3'b000, 1, 3'b001, 1'b1};
        vecs[18] = '{3'b010, 3'b000, 3'b000, 2, 3'b010, 1'b0};
        vecs[19] = '{3'b001, 3'b001, 3'b000, 1, 3'b001, 1'b1};
        vecs[20] = '{3'b001, 3'b001, 3'b000, 1, 3'b001, 1'b1};
        vecs[21] = '{3'b001, 3'b001, 3'b000, 2, 3'b001, 1'b1};
        vecs[22] = '{3'b001, 3'b001, 3'b000, 1, 3'b001, 1'b1};
        vecs[23] = '{3'b001, 3'b001, 3'b000, 1, 3'b001, 1'b0};
        vecs[24] = '{3'b001, 3'b001, 3'b000, 1, 3'b001, 1'b1};

        bus.req_Valid = '0;
        bus.req_Lock  = '0;
        bus.req_WE    = '0;
        bus.req_Addr  = {port_addr[2], port_addr[1], port_addr[0]};
        bus.req_Din   = {port_din[2], port_din[1], port_din[0]};

        // ---- reset state ----
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // ---- single read on port 1, controller answers on 5th BUSY cycle ----
        @(negedge clk);
        bus.req_Valid = 3'b010;
        lat_cfg       = 5;
        @(negedge clk);
        check("single grant", 32'(bus.req_Grant),  32'h2);
        check("single req",   32'(bus.sdram_Req),  32'd1);
        check("single addr",  32'(bus.sdram_Addr), 32'h0000123);
        check("single we",    32'(bus.sdram_WE),   32'd0);
        cyc = 0;
        while (!bus.sdram_R && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("single r_cycle", 32'(cyc), 32'd4);
        check("single ack_early", 32'(bus.req_Ack), 32'd0);
        @(negedge clk);
        check("single ack",  32'(bus.req_Ack),  32'h2);
        check("single dout", 32'(bus.req_Dout), 32'hBEEF);
        bus.req_Valid = '0;
        @(negedge clk);
        check("single idle grant", 32'(bus.req_Grant), 32'd0);
        check("single idle ack",   32'(bus.req_Ack),   32'd0);
        check("single idle req",   32'(bus.sdram_Req), 32'd0);

        // ---- fresh reset, then the vector table ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;

        for (int i = 0; i < NV; i++) begin
            vec_t              v;
            int                p;
            logic [DATA_W-1:0] exp_dout;
            string             tag;
            v   = vecs[i];
            p   = oh2i(v.exp_grant);
            tag = $sformatf("v%0d", i);
            bus.req_Valid = v.valid;
            bus.req_Lock  = v.lock;
            bus.req_WE    = v.we;
            lat_cfg       = v.lat;
            wait_req(tag);
            check({tag, " grant"}, 32'(bus.req_Grant),   32'(v.exp_grant));
            check({tag, " focus"}, 32'(bus.sdram_Focus), 32'(v.exp_focus));
            check({tag, " addr"},  32'(bus.sdram_Addr),  32'(port_addr[p]));
            check({tag, " we"},    32'(bus.sdram_WE),    32'(v.we[p]));
            if (v.we[p]) check({tag, " din"}, 32'(bus.sdram_Din), 32'(port_din[p]));
            wait_ack(tag);
            check({tag, " ack"}, 32'(bus.req_Ack), 32'(v.exp_grant));
            exp_dout = v.we[p] ? last_rd : rd_data(port_addr[p]);
            check({tag, " dout"}, 32'(bus.req_Dout), 32'(exp_dout));
            last_rd = exp_dout;
        end

        // ---- lock release with nothing pending, then sdram_R in IDLE ----
        bus.req_Valid = '0;
        bus.req_Lock  = '0;
        @(negedge clk);
        check("idle focus_fall", 32'(bus.sdram_Focus), 32'd0);
        r_force = 1'b1;
        @(negedge clk);
        r_force = 1'b0;
        check("stray_r ack",   32'(bus.req_Ack),   32'd0);
        check("stray_r req",   32'(bus.sdram_Req), 32'd0);
        check("stray_r grant", 32'(bus.req_Grant), 32'd0);
        @(negedge clk);
        check("stray_r ack2",  32'(bus.req_Ack),   32'd0);

        // ---- reset in the middle of a BUSY access ----
        bus.req_Valid = 3'b010;
        bus.req_WE    = 3'b000;
        lat_cfg       = 50;
        wait_req("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        acks_seen = (bus.req_Ack != '0) ? 1 : 0;
        rst = 1'b0;
        bus.req_Valid = 3'b111;
        lat_cfg = 2;
        cyc = 0;
        @(negedge clk);
        while (!bus.sdram_Req && cyc < 20) begin
            if (bus.req_Ack != '0) acks_seen++;
            @(negedge clk);
            cyc++;
        end
        check("midrst no_ack", 32'(acks_seen), 32'd0);
        check("midrst grant",  32'(bus.req_Grant), 32'h1);
        wait_ack("midrst");
        check("midrst ack", 32'(bus.req_Ack), 32'h1);
        bus.req_Valid = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sdram_arbiter
